dmem_sweeper: RTL and testbench



---
 rtl/sweeper_pkg.sv | 20 ++
 rtl/dmem_sweeper.sv | 145 ++++++++++++++
 tb/tb_dmem_sweeper.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and constants for the data-memory sweeper.
// Peripheral addresses are also used by the data memory and the port mux.
package sweeper_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_HOLD,
        S_FILL,
        S_FIN
    } state_t;

    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam logic [31:0] SW_ADDR  = 32'hC000_0000;
    localparam logic [31:0] LED_ADDR = 32'hC000_0004;

endpackage

// File: rtl/dmem_sweeper.sv
// Data-memory bus initiator: streams a RAM window out with a checksum,
// or fills it with an incrementing pattern.
import sweeper_pkg::*;

module dmem_sweeper #(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      base,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      fill_value,
    output logic             we,
    output logic [31:0]      a,
    output logic [31:0]      wd,
    input  logic [31:0]      rd,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      checksum,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

    state_t           state;
    logic             mode_q;
    logic [31:0]      ptr;
    logic [31:0]      fill_q;
    logic [31:0]      index;
    logic [CNT_W-1:0] remaining;
    logic [32:0]      range_end;
    logic             last;

    // 33-bit end address so base near 2^32 cannot wrap into range.
    assign range_end = {1'b0, ptr}
                     + {{(31 - CNT_W){1'b0}}, remaining, 2'b00};
    assign last      = (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= MODE_READ;
            ptr       <= '0;
            fill_q    <= '0;
            index     <= '0;
            remaining <= '0;
            we        <= 1'b0;
            a         <= '0;
            wd        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr       <= base & ~32'd3;
                        remaining <= count;
                        mode_q    <= mode;
                        fill_q    <= fill_value;
                        index     <= '0;
                        checksum  <= '0;
                        busy      <= 1'b1;
                        state     <= S_CHECK;
                    end
                end
                // Rejected requests finish through FIN so busy covers the err pulse.
                S_CHECK: begin
                    if (range_end > LIMIT) begin
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else if (mode_q == MODE_FILL) begin
                        we    <= 1'b1;
                        a     <= ptr;
                        wd    <= fill_q;
                        state <= S_FILL;
                    end else begin
                        a     <= ptr;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    out_data  <= rd;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        checksum  <= checksum + out_data;
                        ptr       <= ptr + 32'd4;
                        remaining <= remaining - 1'b1;
                        if (last) begin
                            a     <= '0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            a     <= ptr + 32'd4;
                            state <= S_READ;
                        end
                    end
                end
                S_FILL: begin
                    ptr       <= ptr + 32'd4;
                    index     <= index + 32'd1;
                    remaining <= remaining - 1'b1;
                    if (last) begin
                        we    <= 1'b0;
                        a     <= '0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        a     <= ptr + 32'd4;
                        wd    <= fill_q + index + 32'd1;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    we        <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sweeper.sv
// Randomised bench for dmem_sweeper against a window-level memory model.
// A bench RAM answers the data-memory port; a shadow copy holds expectations.
module tb_dmem_sweeper;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [31:0]      base;
    logic [CNT_W-1:0] count;
    logic [31:0]      fill_value;
    logic             we;
    logic [31:0]      a;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      checksum;
    logic             busy;
    logic             done;
    logic             err;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    dmem_sweeper #(.DEPTH_WORDS(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base(base), .count(count), .fill_value(fill_value),
        .we(we), .a(a), .wd(wd), .rd(rd),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .checksum(checksum), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign rd = ram[a[7:2]];

    always @(posedge clk) begin
        if (we) ram[a[7:2]] <= wd;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_wd"}, wd, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic ram_image_check();
        int bad_words = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) bad_words++;
        chk("ram_image", 32'(bad_words), 0);
    endtask

    // rmode: 0 ready high, 1 ready 0,0,1 per held word, 2 random.
    // rst_at >= 0 pulses reset during the write cycle number rst_at.
    task automatic sweep(input logic m, input logic [31:0] b, input int cnt,
                         input logic [31:0] fv, input int rmode,
                         input int rst_at);
        logic [31:0] bb = b & ~32'd3;
        logic bad = (33'(bb) + 33'(4 * cnt)) > 33'(4 * DEPTH);
        int first = int'(bb >> 2);
        int nw = (!bad && m) ? cnt : 0;
        int nr = (!bad && !m) ? cnt : 0;
        logic [31:0] exp_sum = 0;
        int widx = 0, hidx = 0, busyc = 0, cyc = 0, last_ev = 0;
        int hold_n = 0, exp_busy;
        bit fin = 0, pv = 0, phs = 0;
        logic [31:0] pd = 0, pa = 0;

        for (int i = 0; i < nr; i++) exp_sum += ref_mem[first + i];

        @(negedge clk);
        start = 1'b1; mode = m; base = b;
        count = cnt[CNT_W-1:0]; fill_value = fv; out_ready = 1'b0;

        while (!fin && cyc < 600) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) busyc++;
            if (cyc == 1) begin
                chk("check_busy", 32'(busy), 1);
                chk("check_a", a, 0);
            end
            if (we) begin
                if (widx < nw) begin
                    chk("fill_addr", a, bb + 32'(4 * widx));
                    chk("fill_data", wd, fv + 32'(widx));
                    if (widx > 0) chk("fill_gap", 32'(cyc - last_ev), 1);
                end else begin
                    chk("stray_we", 32'(we), 0);
                end
                widx++;
                last_ev = cyc;
                if (rst_at >= 0 && widx == rst_at) begin
                    reset = 1'b1;
                    fin = 1;
                end
            end
            if (out_valid && pv && !phs) begin
                chk("hold_data", out_data, pd);
                chk("hold_addr", a, pa);
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = out_valid && (hold_n % 3 == 2);
                    if (out_valid) hold_n++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            phs = out_valid && out_ready;
            pv = out_valid; pd = out_data; pa = a;
            if (phs) begin
                if (hidx < nr) begin
                    chk("rd_data", out_data, ref_mem[first + hidx]);
                    chk("rd_addr", a, bb + 32'(4 * hidx));
                    if (rmode == 0 && hidx > 0)
                        chk("rd_gap", 32'(cyc - last_ev), 2);
                end else begin
                    chk("stray_valid", 32'(out_valid), 0);
                end
                hidx++;
                last_ev = cyc;
            end
            if (done || err) begin
                fin = 1;
                chk("done", 32'(done), 32'(!bad));
                chk("err", 32'(err), 32'(bad));
                if (nw + nr > 0) chk("fin_lat", 32'(cyc - last_ev), 1);
            end
        end
        out_ready = 1'b0;
        if (rst_at >= 0) return;

        if (!fin) chk("timeout", 0, 1);
        chk("n_writes", 32'(widx), 32'(nw));
        chk("n_reads", 32'(hidx), 32'(nr));
        if (bad || cnt == 0) exp_busy = 2;
        else if (m) exp_busy = cnt + 2;
        else if (rmode == 0) exp_busy = 2 * cnt + 2;
        else exp_busy = -1;
        if (exp_busy >= 0) chk("busy_cycles", 32'(busyc), 32'(exp_busy));

        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_err", 32'(err), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_we", 32'(we), 0);
        chk("checksum", checksum, exp_sum);
        for (int i = 0; i < nw; i++) ref_mem[first + i] = fv + 32'(i);
        ram_image_check();
    endtask

    initial begin
        logic [31:0] fv;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        reset = 1'b1; start = 1'b0; mode = 1'b0; base = '0;
        count = '0; fill_value = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        sweep(1'b1, 32'h10, 4, 32'hA0, 0, -1);
        chk("lit_ram4", ram[4], 32'hA0);
        chk("lit_ram7", ram[7], 32'hA3);
        sweep(1'b0, 32'h10, 4, 0, 0, -1);
        chk("lit_sum", checksum, 32'h286);
        sweep(1'b0, 32'h13, 4, 0, 1, -1);
        chk("lit_sum_stall", checksum, 32'h286);
        sweep(1'b1, 32'hF8, 3, 32'h55, 0, -1);
        chk("lit_err_sum", checksum, 0);
        sweep(1'b0, 32'h20, 0, 0, 0, -1);
        sweep(1'b1, 32'hF0, 4, 32'hFFFF_FFFE, 0, -1);
        sweep(1'b0, 32'h0, DEPTH, 0, 2, -1);
        sweep(1'b0, 32'h4, DEPTH, 0, 0, -1);

        fv = $urandom;
        sweep(1'b1, 32'h10, 4, fv, 0, 2);
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        reset = 1'b0;
        chk("rst_ram4", ram[4], fv);
        chk("rst_ram5", ram[5], fv + 32'd1);
        chk("rst_ram6", ram[6], ref_mem[6]);
        chk("rst_ram7", ram[7], ref_mem[7]);
        ref_mem[4] = fv;
        ref_mem[5] = fv + 32'd1;
        sweep(1'b0, 32'h10, 4, 0, 0, -1);

        for (int t = 0; t < 30; t++) begin
            sweep(1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 68) * 4 + $urandom_range(0, 3)),
                  int'($urandom_range(0, 24)), $urandom,
                  int'($urandom_range(0, 2)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
